// File: rtl/mini_cpu_pkg.sv
// Shared opcode and FSM-state encodings for the mini CPU (control, ALU, top level).
package mini_cpu_pkg;

  typedef enum logic [2:0] {
    OP_LOAD    = 3'b000,
    OP_ADD     = 3'b001,
    OP_ADDI    = 3'b010,
    OP_SUB     = 3'b011,
    OP_SUBI    = 3'b100,
    OP_MUL     = 3'b101,
    OP_CLEAR   = 3'b110,
    OP_DISPLAY = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_IDLE  = 3'd1,
    ST_LATCH = 3'd2,
    ST_READ  = 3'd3,
    ST_EXEC  = 3'd4,
    ST_WRITE = 3'd5,
    ST_CLEAR = 3'd6,
    ST_SHOW  = 3'd7
  } state_e;

  localparam logic [3:0] LAST_ADDR = 4'd15;

endpackage

// File: rtl/module_debounce.sv
// Push-button conditioner: 2-flop synchronizer, optional debounce, rising-edge press pulse.
// Macro CPU_CTRL_DEBOUNCE_EN enables the DEBOUNCE_CYC stable-sample filter.
module module_debounce #(
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic level_s;

  // Synchronizer and edge-history flops
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      prev_q  <= level_s;
    end
  end

`ifdef CPU_CTRL_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic             stable_q;
  logic             stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count consecutive samples that disagree with the accepted level
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
        stable_d = sync2_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Debounce state
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level_s = stable_q;
`else
  // The threshold only matters when debouncing is compiled in.
  logic unused_cfg_s;
  assign unused_cfg_s = ^DEBOUNCE_CYC;
  assign level_s      = sync2_q;
`endif

  assign press_o = level_s & ~prev_q;

endmodule

// File: rtl/module_cpu_control.sv
// Mini CPU sequencer: latches switch instructions, drives RAM/ALU/LCD handshakes.
// Optional debounce on enviar via macro CPU_CTRL_DEBOUNCE_EN (see module_debounce).
module module_cpu_control
  import mini_cpu_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ligar,
  input  logic        enviar,
  input  logic [2:0]  opcode,
  input  logic [3:0]  addr1,
  input  logic [3:0]  addr2,
  input  logic [6:0]  addr3OuImm,
  input  logic [15:0] alu_result,
  input  logic        lcd_ack,
  output logic [2:0]  alu_op,
  output logic        alu_sinal,
  output logic [5:0]  alu_imm,
  output logic [3:0]  ram_raddr1,
  output logic [3:0]  ram_raddr2,
  output logic [3:0]  ram_waddr,
  output logic [15:0] ram_wdata,
  output logic        ram_we,
  output logic        lcd_req,
  output logic [2:0]  lcd_code,
  output logic        busy
);

  logic press_s;

  module_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_debounce (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (enviar),
    .press_o(press_s)
  );

  state_e      state_q, state_d, next_s;
  logic [2:0]  op_q, op_d;
  logic [3:0]  a1_q, a1_d;
  logic [3:0]  a2_q, a2_d;
  logic [6:0]  a3_q, a3_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  raddr1_q, raddr1_d;
  logic [3:0]  raddr2_q, raddr2_d;
  logic [3:0]  waddr_q, waddr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        req_q, req_d;
  logic [2:0]  code_q, code_d;
  logic        busy_q, busy_d;

  // Next state, instruction capture and sweep counter
  always_comb begin
    next_s = state_q;
    op_d   = op_q;
    a1_d   = a1_q;
    a2_d   = a2_q;
    a3_d   = a3_q;
    cnt_d  = cnt_q;
    case (state_q)
      ST_OFF: begin
        if (ligar) begin
          next_s = ST_CLEAR;
          cnt_d  = 4'd0;
        end else begin
          next_s = ST_OFF;
        end
      end
      ST_IDLE: begin
        if (press_s && ligar) begin
          next_s = ST_LATCH;
          op_d   = opcode;
          a1_d   = addr1;
          a2_d   = addr2;
          a3_d   = addr3OuImm;
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_LATCH: begin
        if (op_q == OP_CLEAR) begin
          next_s = ST_CLEAR;
          cnt_d  = 4'd0;
        end else begin
          next_s = ST_READ;
        end
      end
      ST_READ:  next_s = ST_EXEC;
      ST_EXEC:  next_s = (op_q == OP_DISPLAY) ? ST_SHOW : ST_WRITE;
      ST_WRITE: next_s = ST_SHOW;
      ST_CLEAR: begin
        if (cnt_q == LAST_ADDR) begin
          next_s = ST_SHOW;
          cnt_d  = 4'd0;
        end else begin
          next_s = ST_CLEAR;
          cnt_d  = cnt_q + 4'd1;
        end
      end
      ST_SHOW:  next_s = lcd_ack ? ST_IDLE : ST_SHOW;
      default:  next_s = ST_OFF;
    endcase
    state_d = ligar ? next_s : ST_OFF;
  end

  // Outputs are a registered function of the state being entered
  always_comb begin
    we_d     = 1'b0;
    req_d    = 1'b0;
    busy_d   = 1'b1;
    raddr1_d = raddr1_q;
    raddr2_d = raddr2_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    case (state_d)
      ST_OFF, ST_IDLE: busy_d = 1'b0;
      ST_READ: begin
        raddr1_d = (op_q == OP_DISPLAY) ? a1_q : a2_q;
        raddr2_d = a3_q[6:3];
      end
      ST_WRITE: begin
        we_d    = 1'b1;
        waddr_d = a1_q;
        wdata_d = alu_result;
      end
      ST_CLEAR: begin
        we_d    = 1'b1;
        waddr_d = cnt_d;
        wdata_d = 16'h0000;
      end
      ST_SHOW: req_d = 1'b1;
      default: busy_d = 1'b1;
    endcase
    if (state_d == ST_SHOW) begin
      if (state_q == ST_CLEAR) begin
        code_d = OP_CLEAR;
      end else if (state_q == ST_SHOW) begin
        code_d = code_q;
      end else begin
        code_d = op_q;
      end
    end else begin
      code_d = code_q;
    end
  end

  // FSM and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_OFF;
      op_q     <= 3'd0;
      a1_q     <= 4'd0;
      a2_q     <= 4'd0;
      a3_q     <= 7'd0;
      cnt_q    <= 4'd0;
      raddr1_q <= 4'd0;
      raddr2_q <= 4'd0;
      waddr_q  <= 4'd0;
      wdata_q  <= 16'h0000;
      we_q     <= 1'b0;
      req_q    <= 1'b0;
      code_q   <= 3'd0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a1_q     <= a1_d;
      a2_q     <= a2_d;
      a3_q     <= a3_d;
      cnt_q    <= cnt_d;
      raddr1_q <= raddr1_d;
      raddr2_q <= raddr2_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      req_q    <= req_d;
      code_q   <= code_d;
      busy_q   <= busy_d;
    end
  end

  assign alu_op     = op_q;
  assign alu_sinal  = a3_q[6];
  assign alu_imm    = a3_q[5:0];
  assign ram_raddr1 = raddr1_q;
  assign ram_raddr2 = raddr2_q;
  assign ram_waddr  = waddr_q;
  assign ram_wdata  = wdata_q;
  assign ram_we     = we_q;
  assign lcd_req    = req_q;
  assign lcd_code   = code_q;
  assign busy       = busy_q;

endmodule

// File: doc/module_cpu_control.md
MODULE_CPU_CONTROL -- requirements
Module: module_cpu_control

Interface
REQ-001 Parameters SHALL be: DEBOUNCE_CYC, 16, consecutive stable cycles required to accept an enviar level.
REQ-002 Ports SHALL be:
- clk  in  1  sole clock.
- rst  in  1  synchronous active-high reset.
- ligar  in  1  power switch.
- enviar  in  1  raw asynchronous push-button.
- opcode  in  3  instruction switches.
- addr1  in  4  destination register switches.
- addr2  in  4  source-1 register switches.
- addr3OuImm  in  7  source-2 register in [6:3], or sign bit [6] plus magnitude [5:0].
- alu_result  in  16  combinational ALU output.
- lcd_ack  in  1  LCD update done.
- alu_op  out  3  latched opcode to ALU.
- alu_sinal  out  1  latched immediate sign.
- alu_imm  out  6  latched immediate magnitude.
- ram_raddr1  out  4  RAM read port 1 address.
- ram_raddr2  out  4  RAM read port 2 address.
- ram_waddr  out  4  RAM write address.
- ram_wdata  out  16  RAM write data.
- ram_we  out  1  one-cycle RAM write strobe.
- lcd_req  out  1  LCD update request.
- lcd_code  out  3  opcode shown on LCD.
- busy  out  1  instruction in progress.

Function
REQ-003 enviar SHALL pass a 2-flop synchronizer; an accepted press is one rising edge of the conditioned level.
REQ-004 FSM states SHALL be OFF, IDLE, LATCH, READ, EXEC, WRITE, CLEAR, SHOW.
REQ-005 OFF: ram_we=0, lcd_req=0, busy=0, presses ignored; leave to CLEAR on the first cycle ligar=1.
REQ-006 IDLE: busy=0; an accepted press SHALL go to LATCH next cycle.
REQ-007 LATCH: capture opcode, addr1, addr2, addr3OuImm into internal registers; go to CLEAR if opcode=110, else READ.
REQ-008 READ: ram_raddr1=addr2 latched, ram_raddr2=addr3OuImm[6:3] latched; the RAM has 1-cycle read latency; go to EXEC.
REQ-009 EXEC: hold addresses; register alu_result; go to WRITE for 000-101, SHOW for 111 (DISPLAY: no write; ram_raddr1 SHALL equal latched addr1 in READ/EXEC).
REQ-010 WRITE: ram_we=1 for exactly one cycle, ram_waddr=latched addr1, ram_wdata=registered result; go to SHOW.
REQ-011 CLEAR: 4-bit counter sweeps addresses 0..15, ram_we=1 and ram_wdata=0 each cycle (16 cycles); after address 15 go to SHOW.
REQ-012 SHOW: lcd_req=1 and lcd_code=latched opcode (110 after power-on sweep) until the cycle lcd_ack=1 is sampled; then IDLE; lcd_req SHALL drop the cycle after ack.
REQ-013 Latency from accepted press to ram_we for ALU ops SHALL be exactly 4 cycles (LATCH, READ, EXEC, WRITE).
REQ-014 busy SHALL be 1 in LATCH through SHOW; presses while busy SHALL be dropped, not queued.
REQ-015 Switch changes after LATCH SHALL NOT affect the running instruction.
REQ-016 ligar=0 in any state SHALL force OFF next cycle, aborting the instruction or sweep; ram_we and lcd_req SHALL be 0 from that cycle.
REQ-017 ligar falling and an accepted press in the same cycle: ligar wins.
REQ-018 lcd_ack outside SHOW SHALL be ignored.

Reset
REQ-019 rst SHALL force OFF, all outputs 0, latched fields 0, counter 0, synchronizer and debounce state 0; rst has priority over all inputs.
REQ-020 rst mid-CLEAR or mid-WRITE SHALL abort with no further writes.

Configuration
REQ-021 Macro CPU_CTRL_DEBOUNCE_EN: defined, the synchronized enviar SHALL be accepted only after DEBOUNCE_CYC consecutive equal samples; undefined, the synchronized level is used directly and DEBOUNCE_CYC is unused.

Structure
REQ-022 Opcode constants (LOAD=000 ... DISPLAY=111) and the state encoding SHALL live in shared package mini_cpu_pkg, also used by module_mini_cpu and module_alu.
REQ-023 Synchronizer plus debounce SHALL be sub-module module_debounce; the FSM stays in module_cpu_control.

Verification
REQ-024 rst, ligar=1 -> 16 consecutive ram_we cycles with waddr 0..15, wdata=0, then lcd_req with lcd_code=110.
REQ-025 ADD (001), addr1=3, addr2=1, addr3=2, alu_result=0x0007 -> ram_we 4 cycles after accepted press, waddr=3, wdata=0x0007, then SHOW.
REQ-026 DISPLAY (111), addr1=5 -> ram_raddr1=5, no ram_we, lcd_req until lcd_ack, lcd_code=111.
REQ-027 Second press during EXEC -> dropped; exactly one ram_we; IDLE after ack.
REQ-028 ligar=0 at sweep address 7 -> no write after address 7 (ligar-low cycle included), OFF, busy=0.
REQ-029 With CPU_CTRL_DEBOUNCE_EN, enviar glitch of 10 cycles -> no instruction; 20 stable cycles -> one instruction.
